tilemap_fill_engine: RTL and testbench
======================================

Name: tilemap_fill_engine

Overview:
- Command-driven writer for the tilemap memory. Fills a rectangle of tile entries with one 8-bit texture index.
- Drives the tilemap's 32-bit byte-lane write port (wdata / write-enable / 4-bit byte select / 27-bit byte address).
- Merges adjacent tiles in the same 32-bit word into a single write.
- Sits beside the CPU store path; a bus arbiter grants it the tilemap write port.

Parameters:
MAP_WIDTH, 40, tiles per row; row stride in bytes; must be a multiple of 4.
MAP_HEIGHT, 30, tile rows.
BASE_ADDR, 27'h0, byte address of tile (0,0) on the write port; must be word-aligned.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  high only in IDLE
i_x0  in  6  left tile column
i_y0  in  6  top tile row
i_width  in  6  columns to fill
i_height  in  6  rows to fill
i_value  in  8  texture index to write
i_grant  in  1  arbiter grants write port this cycle
o_wdata  out  32  write data
o_wea  out  1  write enable
o_wselect  out  4  byte-lane select, bit n = bits [8n+7:8n]
o_waddr  out  27  word-aligned byte address
o_busy  out  1  high in RUN
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse with o_done on a rejected command

Behaviour:
- Reset values: state IDLE; o_cmd_ready=1; o_wea=0; o_wselect=0; o_wdata=0; o_waddr=0; o_busy=0; o_done=0; o_err=0.
- Reset asserted mid-RUN: at the next edge go to IDLE, o_wea=0. No done pulse. The partial fill is not undone.
- Command accept: on i_cmd_valid & o_cmd_ready, capture all command fields.
- Checks at accept, with 7-bit sums:
  - i_x0+i_width > MAP_WIDTH, or i_y0+i_height > MAP_HEIGHT: go to DONE with err=1.
  - Otherwise, i_width==0 or i_height==0: go to DONE with err=0, no writes.
  - Otherwise: go to RUN with cx=x0, cy=y0, row_base=y0*MAP_WIDTH (12-bit).
- Out-of-range checks take priority over zero-size checks.
- States: IDLE -> RUN | DONE; RUN -> DONE after the last write; DONE -> IDLE after one cycle. o_done (and o_err if set) is high exactly during DONE.
- RUN, per cycle:
  - a = row_base + cx; lane = a[1:0].
  - rem = x0+width-cx; n = min(4-lane, rem).
  - o_wselect has bits lane..lane+n-1 set.
  - o_wdata = {4{value}}.
  - o_waddr = BASE_ADDR + {a[11:2],2'b00}, zero-extended.
  - These are registered outputs, valid in the same cycle o_wea is high.
- Write completes when o_wea & i_grant: o_wea = (state==RUN) & i_grant, combinational on i_grant.
- On a completed write: cx += n. If cx reaches x0+width, then cx=x0, cy+=1, row_base+=MAP_WIDTH. If cy then reaches y0+height, go to DONE.
- i_grant low: no advance, address/select/data held, o_wea=0.
- Since MAP_WIDTH%4==0, a row never shares a word with another row. Each row costs ceil((lane0+width)/4) writes, where lane0 = x0[1:0].
- Address arithmetic: 12-bit byte index, max 1199 at default size; never wraps for in-range commands.
- i_cmd_valid is ignored outside IDLE; there is no queuing.

Decomposition:
- Shared package tilemap_pkg: MAP_WIDTH/MAP_HEIGHT constants, index widths (6-bit tile coord, 12-bit byte index, 27-bit bus address), FSM state encoding IDLE/RUN/DONE.
- One natural sub-module, tilemap_lane_mask: combinational (lane, rem) -> (n, 4-bit wselect), reusable by the CPU-side byte store path.

Test Plan:
1. x0=0,y0=0,w=40,h=1,val=8'h5A, grant=1 -> 10 writes, waddr 0,4,...,36, wselect 4'hF, wdata 32'h5A5A5A5A; then o_done 1 cycle, o_err=0.
2. x0=1,y0=2,w=6,h=1,val=8'h07 -> 2 writes: waddr 80 sel 4'b1110, then waddr 84 sel 4'b0111; then done.
3. x0=3,y0=0,w=1,h=3 -> 3 writes: waddr 0/40/80, each sel 4'b1000; row advance correct.
4. x0=39,w=2,h=1 -> DONE next cycle with o_err=1, zero o_wea cycles. Repeat with w=0 -> o_done=1, o_err=0, no writes. y0=29,h=2 -> o_err=1.
5. Test 1 with i_grant low for 5 cycles after the 3rd write -> o_wea=0 and outputs stable while low; total still 10 writes, identical address sequence.
6. rst high during the 4th write of test 1 -> next cycle o_wea=0, o_cmd_ready=1, no o_done. A new command (test 2) then runs correctly.

Source files
------------

// File: rtl/tilemap_pkg.sv
// Shared constants, widths and FSM encoding for the tilemap fill engine.
// Imported by the fill engine top and its lane-mask helper.
package tilemap_pkg;

    localparam int DEF_MAP_WIDTH  = 40;
    localparam int DEF_MAP_HEIGHT = 30;

    localparam int COORD_W = 6;
    localparam int SPAN_W  = 7;
    localparam int IDX_W   = 12;
    localparam int ADDR_W  = 27;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [SPAN_W-1:0]  span_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tilemap_lane_mask.sv
// Byte-lane mask: given the starting lane in a 32-bit word and the bytes
// remaining, returns how many bytes fit in this word and their select mask.
// Ports: i_lane (start lane), i_rem (bytes left) -> o_n (1..4), o_sel.
module tilemap_lane_mask
    import tilemap_pkg::*;
(
    input  logic [1:0] i_lane,
    input  span_t      i_rem,
    output logic [2:0] o_n,
    output logic [3:0] o_sel
);

    logic [2:0] avail;
    logic [3:0] ones;

    always_comb begin
        avail = 3'd4 - {1'b0, i_lane};
        if (i_rem < {4'b0, avail}) begin
            o_n = i_rem[2:0];
        end else begin
            o_n = avail;
        end
        // 4-bit wrap makes n=4 yield 4'hF
        ones  = (4'd1 << o_n) - 4'd1;
        o_sel = ones << i_lane;
    end

endmodule

// File: rtl/tilemap_fill_engine.sv
// Fills a rectangle of tilemap bytes with one texture index, merging tiles
// that share a 32-bit word into a single byte-lane write.
// Ports: command (valid/ready, x0/y0/width/height/value), write port
// (wdata/wea/wselect/waddr, gated by i_grant), status (busy/done/err).
module tilemap_fill_engine
    import tilemap_pkg::*;
#(
    parameter int          MAP_WIDTH  = DEF_MAP_WIDTH,
    parameter int          MAP_HEIGHT = DEF_MAP_HEIGHT,
    parameter logic [26:0] BASE_ADDR  = 27'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [5:0]  i_x0,
    input  logic [5:0]  i_y0,
    input  logic [5:0]  i_width,
    input  logic [5:0]  i_height,
    input  logic [7:0]  i_value,
    input  logic        i_grant,
    output logic [31:0] o_wdata,
    output logic        o_wea,
    output logic [3:0]  o_wselect,
    output logic [26:0] o_waddr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam span_t W_LIM      = 7'(MAP_WIDTH);
    localparam span_t H_LIM      = 7'(MAP_HEIGHT);
    localparam idx_t  ROW_STRIDE = 12'(MAP_WIDTH);

    logic [1:0]  state_q, state_d;
    coord_t      x0_q, x0_d;
    span_t       xend_q, xend_d;
    span_t       yend_q, yend_d;
    logic [7:0]  value_q, value_d;
    span_t       cx_q, cx_d;
    span_t       cy_q, cy_d;
    idx_t        row_base_q, row_base_d;
    logic        err_q, err_d;
    logic [2:0]  n_q, n_d;
    logic [3:0]  wsel_q, wsel_d;
    logic [31:0] wdata_q, wdata_d;
    addr_t       waddr_q, waddr_d;

    span_t       sum_x, sum_y, cx_adv, rem_d;
    idx_t        a_d;
    logic [2:0]  n_m;
    logic [3:0]  sel_m;

    // Mask for the write that will be presented next cycle, so the
    // registered outputs line up with o_wea.
    tilemap_lane_mask u_mask (
        .i_lane (a_d[1:0]),
        .i_rem  (rem_d),
        .o_n    (n_m),
        .o_sel  (sel_m)
    );

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        xend_d     = xend_q;
        yend_d     = yend_q;
        value_d    = value_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        row_base_d = row_base_q;
        err_d      = err_q;
        sum_x      = {1'b0, i_x0} + {1'b0, i_width};
        sum_y      = {1'b0, i_y0} + {1'b0, i_height};
        cx_adv     = cx_q + {4'b0, n_q};

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    x0_d       = i_x0;
                    xend_d     = sum_x;
                    yend_d     = sum_y;
                    value_d    = i_value;
                    cx_d       = {1'b0, i_x0};
                    cy_d       = {1'b0, i_y0};
                    row_base_d = {6'b0, i_y0} * ROW_STRIDE;
                    if (sum_x > W_LIM || sum_y > H_LIM) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (i_width == '0 || i_height == '0) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_grant) begin
                    if (cx_adv == xend_q) begin
                        cx_d       = {1'b0, x0_q};
                        cy_d       = cy_q + 7'd1;
                        row_base_d = row_base_q + ROW_STRIDE;
                        if (cy_d == yend_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cx_d = cx_adv;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        a_d   = row_base_d + {5'b0, cx_d};
        rem_d = xend_d - cx_d;

        if (state_d == ST_RUN) begin
            n_d     = n_m;
            wsel_d  = sel_m;
            wdata_d = {4{value_d}};
            waddr_d = BASE_ADDR + {15'b0, a_d[11:2], 2'b00};
        end else begin
            n_d     = '0;
            wsel_d  = '0;
            wdata_d = '0;
            waddr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            xend_q     <= '0;
            yend_q     <= '0;
            value_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            row_base_q <= '0;
            err_q      <= 1'b0;
            n_q        <= '0;
            wsel_q     <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            xend_q     <= xend_d;
            yend_q     <= yend_d;
            value_q    <= value_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            row_base_q <= row_base_d;
            err_q      <= err_d;
            n_q        <= n_d;
            wsel_q     <= wsel_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q == ST_RUN);
    assign o_done      = (state_q == ST_DONE);
    assign o_err       = (state_q == ST_DONE) & err_q;
    assign o_wea       = (state_q == ST_RUN) & i_grant;
    assign o_wselect   = wsel_q;
    assign o_wdata     = wdata_q;
    assign o_waddr     = waddr_q;

endmodule

// File: tb/tb_tilemap_fill_engine.sv
// Directed bench for tilemap_fill_engine: reset, merged row writes,
// column walks, rejected/empty commands, grant stalls, mid-run reset.
module tb_tilemap_fill_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [5:0]  i_x0, i_y0, i_width, i_height;
    logic [7:0]  i_value;
    logic        i_grant;
    logic [31:0] o_wdata;
    logic        o_wea;
    logic [3:0]  o_wselect;
    logic [26:0] o_waddr;
    logic        o_busy, o_done, o_err;

    int errors = 0;
    int checks = 0;

    logic [26:0] got_a[$];
    logic [3:0]  got_s[$];
    logic [31:0] got_d[$];
    logic [26:0] stall_a[$];
    logic [3:0]  stall_s[$];
    int          stall_wea;
    bit          got_done, got_err, timed_out, busy_bad;
    int          done_cyc;

    always #5 clk = ~clk;

    tilemap_fill_engine dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_x0        (i_x0),
        .i_y0        (i_y0),
        .i_width     (i_width),
        .i_height    (i_height),
        .i_value     (i_value),
        .i_grant     (i_grant),
        .o_wdata     (o_wdata),
        .o_wea       (o_wea),
        .o_wselect   (o_wselect),
        .o_waddr     (o_waddr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    task automatic issue(input logic [5:0] x0, input logic [5:0] y0,
                         input logic [5:0] w, input logic [5:0] h,
                         input logic [7:0] v);
        @(posedge clk); #1;
        i_x0 = x0; i_y0 = y0; i_width = w; i_height = h; i_value = v;
        i_cmd_valid = 1'b1;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    // Records the write stream until o_done; optionally drops grant for
    // stall_len cycles after write number stall_after.
    task automatic collect(input int stall_after, input int stall_len);
        int writes = 0;
        int stall_left = 0;
        got_a.delete(); got_s.delete(); got_d.delete();
        stall_a.delete(); stall_s.delete();
        stall_wea = 0; got_done = 0; got_err = 0;
        timed_out = 1; busy_bad = 0; done_cyc = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            i_grant = (stall_left > 0) ? 1'b0 : 1'b1;
            #1;
            if (o_done) begin
                got_done = 1; got_err = o_err; done_cyc = cyc;
                timed_out = 0;
                break;
            end
            if (stall_left > 0) begin
                stall_a.push_back(o_waddr);
                stall_s.push_back(o_wselect);
                if (o_wea) stall_wea++;
                stall_left--;
            end else if (o_wea) begin
                got_a.push_back(o_waddr);
                got_s.push_back(o_wselect);
                got_d.push_back(o_wdata);
                if (o_busy !== 1'b1) busy_bad = 1;
                writes++;
                if (writes == stall_after) stall_left = stall_len;
            end
            @(posedge clk); #1;
        end
        i_grant = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_cmd_valid = 1'b0; i_grant = 1'b1;
        i_x0 = '0; i_y0 = '0; i_width = '0; i_height = '0; i_value = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_cmd_ready, o_wea, o_busy, o_done, o_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {o_cmd_ready, o_wea, o_busy, o_done, o_err});
        end
        checks++;
        if ({o_wselect, o_wdata, o_waddr} !== 63'd0) begin
            errors++;
            $display("FAIL reset_bus sel=%h data=%h addr=%h want 0",
                     o_wselect, o_wdata, o_waddr);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_row;
        issue(6'd0, 6'd0, 6'd40, 6'd1, 8'h5A);
        collect(-1, 0);
        checks++;
        if (timed_out || got_a.size() != 10) begin
            errors++;
            $display("FAIL full_row_count got %0d want 10 (timeout=%0d)",
                     got_a.size(), timed_out);
        end
        for (int i = 0; i < got_a.size() && i < 10; i++) begin
            checks++;
            if (got_a[i] !== 27'(4 * i) || got_s[i] !== 4'hF ||
                got_d[i] !== 32'h5A5A5A5A) begin
                errors++;
                $display("FAIL full_row_w%0d got a=%0d s=%h d=%h want a=%0d s=f d=5a5a5a5a",
                         i, got_a[i], got_s[i], got_d[i], 4 * i);
            end
        end
        checks++;
        if (got_done !== 1'b1 || got_err !== 1'b0 || busy_bad) begin
            errors++;
            $display("FAIL full_row_done got done=%0d err=%0d busy_bad=%0d want 1 0 0",
                     got_done, got_err, busy_bad);
        end
        @(posedge clk); #2;
        checks++;
        if (o_done !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_one_cycle got done=%b ready=%b want 0 1",
                     o_done, o_cmd_ready);
        end
    endtask

    task automatic test_partial_word;
        issue(6'd1, 6'd2, 6'd6, 6'd1, 8'h07);
        collect(-1, 0);
        checks++;
        if (got_a.size() != 2 || !got_done || got_err) begin
            errors++;
            $display("FAIL partial_count got %0d done=%0d err=%0d want 2 1 0",
                     got_a.size(), got_done, got_err);
        end else begin
            checks++;
            if (got_a[0] !== 27'd80 || got_s[0] !== 4'b1110 ||
                got_d[0] !== 32'h07070707) begin
                errors++;
                $display("FAIL partial_w0 got a=%0d s=%b d=%h want 80 1110 07070707",
                         got_a[0], got_s[0], got_d[0]);
            end
            checks++;
            if (got_a[1] !== 27'd84 || got_s[1] !== 4'b0111) begin
                errors++;
                $display("FAIL partial_w1 got a=%0d s=%b want 84 0111",
                         got_a[1], got_s[1]);
            end
        end
    endtask

    task automatic test_column;
        logic [26:0] exp_a[3];
        exp_a = '{27'd0, 27'd40, 27'd80};
        issue(6'd3, 6'd0, 6'd1, 6'd3, 8'hC3);
        collect(-1, 0);
        checks++;
        if (got_a.size() != 3 || !got_done || got_err) begin
            errors++;
            $display("FAIL column_count got %0d done=%0d err=%0d want 3 1 0",
                     got_a.size(), got_done, got_err);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_a[i] !== exp_a[i] || got_s[i] !== 4'b1000 ||
                    got_d[i] !== 32'hC3C3C3C3) begin
                    errors++;
                    $display("FAIL column_w%0d got a=%0d s=%b d=%h want %0d 1000 c3c3c3c3",
                             i, got_a[i], got_s[i], got_d[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_reject;
        logic [5:0] cx0[4], cy0[4], cw[4], ch[4];
        logic       cerr[4];
        cx0 = '{6'd39, 6'd39, 6'd0, 6'd5};
        cy0 = '{6'd0,  6'd0,  6'd29, 6'd3};
        cw  = '{6'd2,  6'd0,  6'd1,  6'd4};
        ch  = '{6'd1,  6'd1,  6'd2,  6'd0};
        cerr = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            issue(cx0[k], cy0[k], cw[k], ch[k], 8'hEE);
            collect(-1, 0);
            checks++;
            if (got_a.size() != 0 || done_cyc != 0 || got_err !== cerr[k]) begin
                errors++;
                $display("FAIL reject_%0d got writes=%0d done_cyc=%0d err=%0d want 0 0 %0d",
                         k, got_a.size(), done_cyc, got_err, cerr[k]);
            end
        end
        // Bottom-right corner word: last legal bytes 1196..1199
        issue(6'd36, 6'd29, 6'd4, 6'd1, 8'h11);
        collect(-1, 0);
        checks++;
        if (got_a.size() != 1 || got_err || !got_done) begin
            errors++;
            $display("FAIL corner_count got %0d err=%0d want 1 0",
                     got_a.size(), got_err);
        end else begin
            checks++;
            if (got_a[0] !== 27'd1196 || got_s[0] !== 4'hF) begin
                errors++;
                $display("FAIL corner_w0 got a=%0d s=%h want 1196 f",
                         got_a[0], got_s[0]);
            end
        end
    endtask

    task automatic test_grant_stall;
        issue(6'd0, 6'd0, 6'd40, 6'd1, 8'h5A);
        collect(3, 5);
        checks++;
        if (got_a.size() != 10 || !got_done || got_err) begin
            errors++;
            $display("FAIL stall_count got %0d done=%0d want 10 1",
                     got_a.size(), got_done);
        end
        for (int i = 0; i < got_a.size() && i < 10; i++) begin
            checks++;
            if (got_a[i] !== 27'(4 * i) || got_s[i] !== 4'hF) begin
                errors++;
                $display("FAIL stall_w%0d got a=%0d s=%h want %0d f",
                         i, got_a[i], got_s[i], 4 * i);
            end
        end
        checks++;
        if (stall_a.size() != 5 || stall_wea != 0) begin
            errors++;
            $display("FAIL stall_cycles got %0d wea=%0d want 5 0",
                     stall_a.size(), stall_wea);
        end
        for (int i = 0; i < stall_a.size(); i++) begin
            checks++;
            if (stall_a[i] !== 27'd12 || stall_s[i] !== 4'hF) begin
                errors++;
                $display("FAIL stall_hold%0d got a=%0d s=%h want 12 f",
                         i, stall_a[i], stall_s[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int seen = 0;
        bit hit = 0;
        issue(6'd0, 6'd0, 6'd40, 6'd1, 8'h5A);
        for (int cyc = 0; cyc < 50; cyc++) begin
            i_grant = 1'b1;
            #1;
            if (o_wea) seen++;
            if (seen == 4) begin
                rst = 1'b1;
                hit = 1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrst_reach got writes=%0d want 4", seen);
        end
        #1;
        checks++;
        if ({o_wea, o_cmd_ready, o_done, o_busy} !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_state got wea/rdy/done/busy=%b want 0100",
                     {o_wea, o_cmd_ready, o_done, o_busy});
        end
        @(posedge clk); #2;
        checks++;
        if (o_done !== 1'b0 || o_wea !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone got done=%b wea=%b want 0 0",
                     o_done, o_wea);
        end
        issue(6'd1, 6'd2, 6'd6, 6'd1, 8'h07);
        collect(-1, 0);
        checks++;
        if (got_a.size() != 2 || !got_done || got_err) begin
            errors++;
            $display("FAIL midrst_rerun_count got %0d done=%0d want 2 1",
                     got_a.size(), got_done);
        end else begin
            checks++;
            if (got_a[0] !== 27'd80 || got_s[0] !== 4'b1110 ||
                got_a[1] !== 27'd84 || got_s[1] !== 4'b0111) begin
                errors++;
                $display("FAIL midrst_rerun got %0d/%b %0d/%b want 80/1110 84/0111",
                         got_a[0], got_s[0], got_a[1], got_s[1]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_full_row;
        test_partial_word;
        test_column;
        test_reject;
        test_grant_stall;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
